// File: rtl/freq_pkg.sv
// Shared helpers for the frequency-counter path (density source and averager).
// Provides the counter width rule and the target clamp used on handshake accept.
package freq_pkg;

    // Width able to hold the values 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Requested densities above the window length saturate to all-ones.
    function automatic int unsigned clamp_target(
        input int unsigned t,
        input int unsigned depth
    );
        return (t > depth) ? depth : t;
    endfunction

endpackage

// File: rtl/pdm_step.sv
// First-order error-accumulator PDM step: adds the active density to the
// accumulator each enabled cycle and emits a one whenever it crosses DEPTH.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   step_i      - advance one step this cycle; otherwise hold acc, bit_o <= 0
//   clr_i       - last step of the window: acc restarts at 0 after this step
//   active_i    - ones-per-window governing this step
//   bit_o       - registered output bit
module pdm_step
    import freq_pkg::*;
#(
    parameter int DEPTH = 1000,
    parameter int W     = cnt_w(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step_i,
    input  logic         clr_i,
    input  logic [W-1:0] active_i,
    output logic         bit_o
);

    localparam logic [W:0] MOD = (W+1)'(DEPTH);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic         bit_d;
    logic [W:0]   sum;
    logic [W:0]   diff;

    // acc < DEPTH and active <= DEPTH, so one subtraction keeps acc in range.
    always_comb begin
        sum  = {1'b0, acc_q} + {1'b0, active_i};
        diff = sum - MOD;
        if (sum >= MOD) begin
            bit_d = 1'b1;
            acc_d = diff[W-1:0];
        end else begin
            bit_d = 1'b0;
            acc_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            bit_o <= 1'b0;
        end else if (step_i) begin
            bit_o <= bit_d;
            acc_q <= clr_i ? '0 : acc_d;
        end else begin
            bit_o <= 1'b0;
        end
    end

endmodule

// File: rtl/density_gen.sv
// Bitstream source emitting exactly N ones in every aligned DEPTH-cycle window,
// with the target loaded through valid/ready and applied at window boundaries.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   enable_i        - step per cycle when 1; freeze state and force data_o=0 when 0
//   target_i        - requested ones-per-window (clamped to DEPTH on accept)
//   target_valid_i  - target_i valid; target_ready_o - pending slot empty
//   data_o          - generated bitstream (registered)
//   window_start_o  - high while data_o carries step 0 of a window
//   active_o        - target governing the window currently on data_o
module density_gen
    import freq_pkg::*;
#(
    parameter  int DEPTH = 1000,
    localparam int W     = cnt_w(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable_i,
    input  logic [W-1:0] target_i,
    input  logic         target_valid_i,
    output logic         target_ready_o,
    output logic         data_o,
    output logic         window_start_o,
    output logic [W-1:0] active_o
);

    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    logic [W-1:0] win_cnt_q, win_cnt_d;
    logic [W-1:0] active_q,  active_d;
    logic [W-1:0] pend_q,    pend_d;
    logic         pend_full_q, pend_full_d;
    logic         ws_q,      ws_d;
    logic [W-1:0] act_o_q,   act_o_d;

    logic         last;
    logic         xfer;
    logic [W-1:0] tgt_c;

    assign last  = (win_cnt_q == LAST);
    assign xfer  = target_valid_i & ~pend_full_q;
    assign tgt_c = W'(clamp_target(32'(target_i), DEPTH));

    always_comb begin
        win_cnt_d   = win_cnt_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        ws_d        = 1'b0;
        act_o_d     = act_o_q;
        if (enable_i) begin
            ws_d      = (win_cnt_q == '0);
            // Copy of the value used by this step, so it lines up with data_o.
            act_o_d   = active_q;
            win_cnt_d = last ? '0 : win_cnt_q + 1'b1;
        end
        if (enable_i && last) begin
            if (pend_full_q) begin
                active_d    = pend_q;
                pend_full_d = 1'b0;
            end else if (xfer) begin
                // Empty slot at the boundary: skip the pending register.
                active_d = tgt_c;
            end
        end else if (xfer) begin
            pend_d      = tgt_c;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_q   <= '0;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ws_q        <= 1'b0;
            act_o_q     <= '0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ws_q        <= ws_d;
            act_o_q     <= act_o_d;
        end
    end

    pdm_step #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_pdm (
        .clk      (clk),
        .reset    (reset),
        .step_i   (enable_i),
        .clr_i    (last),
        .active_i (active_q),
        .bit_o    (data_o)
    );

    assign target_ready_o = ~pend_full_q;
    assign window_start_o = ws_q;
    assign active_o       = act_o_q;

endmodule

// File: tb/tb_density_gen.sv
// Directed bench for density_gen: DEPTH=10 instance for window patterns and
// handshake corners, DEPTH=1000 instance for the long-run density check.
module tb_density_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] tgt;
    logic       vld;
    logic       rdy;
    logic       d;
    logic       ws;
    logic [3:0] act;

    logic       rst2;
    logic       en2;
    logic [9:0] tgt2;
    logic       vld2;
    logic       rdy2;
    logic       d2;
    logic       ws2;
    logic [9:0] act2;

    int total = 0;
    int bad   = 0;

    density_gen #(.DEPTH(10)) dut (
        .clk            (clk),
        .reset          (rst),
        .enable_i       (en),
        .target_i       (tgt),
        .target_valid_i (vld),
        .target_ready_o (rdy),
        .data_o         (d),
        .window_start_o (ws),
        .active_o       (act)
    );

    density_gen #(.DEPTH(1000)) dut2 (
        .clk            (clk),
        .reset          (rst2),
        .enable_i       (en2),
        .target_i       (tgt2),
        .target_valid_i (vld2),
        .target_ready_o (rdy2),
        .data_o         (d2),
        .window_start_o (ws2),
        .active_o       (act2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; drops valid once the edge has accepted it.
    task automatic tick();
        logic hs;
        hs = vld & rdy;
        @(posedge clk);
        #1;
        if (hs) vld = 1'b0;
    endtask

    // Runs one full window (10 enabled steps) and checks its bit pattern.
    task automatic next_window(input string tag, input int exp_bits,
                               input int exp_act, input int early,
                               input int late, input int offer,
                               input int r0, input int pz);
        logic [9:0] bits;
        bits = '0;
        if (early >= 0) begin
            tgt = 4'(early);
            vld = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 9 && late >= 0) begin
                tgt = 4'(late);
                vld = 1'b1;
            end
            if (i == pz) begin
                en = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk({tag, "_pause_d"}, 32'(d), 0);
                    chk({tag, "_pause_ws"}, 32'(ws), 0);
                    chk({tag, "_pause_act"}, 32'(act), exp_act);
                end
                en = 1'b1;
            end
            tick();
            bits[i] = d;
            if (i == 0) begin
                chk({tag, "_ws"}, 32'(ws), 1);
                chk({tag, "_act"}, 32'(act), exp_act);
                chk({tag, "_rdy"}, 32'(rdy), r0);
                if (offer >= 0) begin
                    tgt = 4'(offer);
                    vld = 1'b1;
                end
            end else begin
                chk({tag, "_ws_mid"}, 32'(ws), 0);
            end
        end
        chk({tag, "_bits"}, 32'(bits), exp_bits);
    endtask

    initial begin
        int cnt;
        bit found;
        rst  = 1'b1; en  = 1'b0; tgt  = '0; vld  = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; tgt2 = '0; vld2 = 1'b0;
        tick();
        tick();
        chk("rst_d", 32'(d), 0);
        chk("rst_ws", 32'(ws), 0);
        chk("rst_act", 32'(act), 0);
        chk("rst_rdy", 32'(rdy), 1);

        // Preload 3 while disabled: it waits in the pending slot.
        rst = 1'b0;
        tgt = 4'd3;
        vld = 1'b1;
        tick();
        chk("pre_rdy", 32'(rdy), 0);
        chk("pre_d", 32'(d), 0);
        chk("pre_ws", 32'(ws), 0);
        en = 1'b1;

        next_window("A", 0,    0,  -1, -1, -1, 0, -1);
        next_window("B", 584,  3,  10, -1, -1, 0, -1);
        next_window("C", 1023, 10, 15, -1, -1, 0, -1);
        next_window("D", 1023, 10, 0,  -1, -1, 0, -1);
        next_window("E", 0,    0,  4,  -1, 7,  0, -1);
        next_window("F", 660,  4,  -1, -1, -1, 0, -1);
        next_window("G", 950,  7,  -1, 2,  -1, 1, -1);
        chk("byp_rdy", 32'(rdy), 1);
        chk("byp_vld_taken", 32'(vld), 0);
        next_window("H", 528,  2,  -1, -1, -1, 1, -1);
        next_window("I", 528,  2,  -1, -1, -1, 1, 5);

        // Reset mid-window discards a pending target.
        tgt = 4'd5;
        vld = 1'b1;
        tick();
        chk("mid_rdy", 32'(rdy), 0);
        rst = 1'b1;
        tick();
        chk("mrst_d", 32'(d), 0);
        chk("mrst_ws", 32'(ws), 0);
        chk("mrst_act", 32'(act), 0);
        chk("mrst_rdy", 32'(rdy), 1);
        rst = 1'b0;
        next_window("J", 0, 0, -1, -1, -1, 1, -1);
        next_window("K", 0, 0, -1, -1, -1, 1, -1);

        // Long run at DEPTH=1000, target 250.
        en   = 1'b0;
        rst2 = 1'b0;
        tgt2 = 10'd250;
        vld2 = 1'b1;
        tick();
        vld2 = 1'b0;
        chk("L_rdy", 32'(rdy2), 0);
        en2 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2100 && !found; i++) begin
            tick();
            if (d2 === 1'b1) found = 1'b1;
        end
        chk("L_first_one", 32'(found), 1);
        chk("L_act", 32'(act2), 250);
        cnt = 1;
        for (int i = 0; i < 999; i++) begin
            tick();
            cnt += int'(d2);
        end
        chk("L_avg", 32'(cnt), 250);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            cnt += int'(d2);
        end
        chk("L_avg_part", 32'(cnt), 100);
        rst2 = 1'b1;
        tick();
        chk("L_rst_d", 32'(d2), 0);
        chk("L_rst_ws", 32'(ws2), 0);
        chk("L_rst_act", 32'(act2), 0);
        chk("L_rst_rdy", 32'(rdy2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
